hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle MUL occupancy of ID,
// taken-branch IF/ID flush, and a saturating count of stall cycles.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4  // cycles a MUL occupies ID, legal 2..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_RS1_i,
  input  logic [4:0]  ID_RS2_i,
  input  logic        ID_UseRS1_i,
  input  logic        ID_UseRS2_i,
  input  logic        ID_IsMul_i,
  input  logic        Branch_taken_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_RegisterRd_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFIDFlush_o,
  output logic        IDEXBubble_o,
  output logic        MulStart_o,
  output logic        MulBusy_o,
  output logic [31:0] StallCount_o
);

  typedef enum logic {
    IDLE,
    MUL_BUSY
  } state_t;

  // Counter preload: the launch cycle is itself a stall, so the busy phase
  // holds MUL_LAT-1 cycles, the last of which releases the pipeline.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [31:0] stall_count;
  logic        lu;
  logic        stall;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = EX_MemRead_i && (EX_RegisterRd_i != 5'd0) &&
              ((ID_UseRS1_i && (EX_RegisterRd_i == ID_RS1_i)) ||
               (ID_UseRS2_i && (EX_RegisterRd_i == ID_RS2_i)));

  // Next-state and output decode; priority is load-use, then MUL, then branch.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_next  = state;
    cnt_next    = cnt;
    stall       = 1'b0;
    IFIDFlush_o = 1'b0;
    MulStart_o  = 1'b0;
    MulBusy_o   = 1'b0;

    if (!rst_i) begin
      unique case (state)
        IDLE: begin
          if (lu) begin
            stall = 1'b1;
          end else if (ID_IsMul_i) begin
            stall      = 1'b1;
            MulStart_o = 1'b1;
            cnt_next   = MUL_CNT_INIT;
            state_next = MUL_BUSY;
          end else if (Branch_taken_i) begin
            IFIDFlush_o = 1'b1;
          end
        end

        MUL_BUSY: begin
          MulBusy_o = 1'b1;
          if (cnt > 4'd1) begin
            stall    = 1'b1;
            cnt_next = cnt - 4'd1;
          end else begin
            // cnt==1 is the release cycle; cnt==0 cannot occur here but is
            // treated the same so the FSM can never lock up.
            cnt_next   = 4'd0;
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  assign PCWrite_o    = !stall;
  assign IFIDWrite_o  = !stall;
  assign IDEXBubble_o = stall;
  // The count is masked while reset is held so every output reads as idle.
  assign StallCount_o = rst_i ? 32'd0 : stall_count;

  // State register and MUL occupancy counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Saturating stall-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_count <= 32'd0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT=4). Inputs change just after the
// falling edge; outputs are sampled 1 time unit later, well before the next
// rising edge.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        id_is_mul;
  logic        branch_taken;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        mul_start;
  logic        mul_busy;
  logic [31:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  // Packed view {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulStart, MulBusy}
  localparam logic [5:0] NORMAL     = 6'b110000;
  localparam logic [5:0] STALL      = 6'b000100;
  localparam logic [5:0] FLUSH      = 6'b111000;
  localparam logic [5:0] MUL_LAUNCH = 6'b000110;
  localparam logic [5:0] BUSY_STALL = 6'b000101;
  localparam logic [5:0] BUSY_GO    = 6'b110001;

  logic [5:0] ctl;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, mul_start, mul_busy};

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ID_RS1_i       (id_rs1),
    .ID_RS2_i       (id_rs2),
    .ID_UseRS1_i    (id_use_rs1),
    .ID_UseRS2_i    (id_use_rs2),
    .ID_IsMul_i     (id_is_mul),
    .Branch_taken_i (branch_taken),
    .EX_MemRead_i   (ex_mem_read),
    .EX_RegisterRd_i(ex_rd),
    .PCWrite_o      (pc_write),
    .IFIDWrite_o    (ifid_write),
    .IFIDFlush_o    (ifid_flush),
    .IDEXBubble_o   (idex_bubble),
    .MulStart_o     (mul_start),
    .MulBusy_o      (mul_busy),
    .StallCount_o   (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, then settle.
  task automatic drive(input logic r, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic mul, input logic br);
    @(negedge clk);
    rst          = r;
    ex_mem_read  = mr;
    ex_rd        = rd;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_is_mul    = mul;
    branch_taken = br;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ex_mem_read = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_is_mul = 1'b0; branch_taken = 1'b0;

    // Reset overrides every hazard input
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_ctl_a", 32'(ctl), 32'(NORMAL));
    check("rst_cnt_a", stall_count, 32'd0);
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_ctl_b", 32'(ctl), 32'(NORMAL));
    idle();
    check("idle_ctl", 32'(ctl), 32'(NORMAL));
    check("idle_cnt", stall_count, 32'd0);

    // Load-use on rs2: exactly one stall cycle
    drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lu_rs2_ctl", 32'(ctl), 32'(STALL));
    idle();
    check("lu_after_ctl", 32'(ctl), 32'(NORMAL));
    check("lu_cnt", stall_count, 32'd1);

    // rd = x0 never hazards; unused operand never hazards
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("x0_ctl", 32'(ctl), 32'(NORMAL));
    drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("unused_rs1_ctl", 32'(ctl), 32'(NORMAL));
    // Same match with rs1 in use does hazard
    drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rs1_ctl", 32'(ctl), 32'(STALL));
    idle();
    check("lu_rs1_cnt", stall_count, 32'd2);

    // Clear the count, then a single MUL with hazard/branch noise while busy
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst2_cnt", stall_count, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mul_launch", 32'(ctl), 32'(MUL_LAUNCH));
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    check("mul_busy1", 32'(ctl), 32'(BUSY_STALL));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mul_busy2_noflush", 32'(ctl), 32'(BUSY_STALL));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("mul_busy3_release", 32'(ctl), 32'(BUSY_GO));
    idle();
    check("mul_done_ctl", 32'(ctl), 32'(NORMAL));
    check("mul_cnt", stall_count, 32'd3);

    // Priority: load-use beats MUL and branch; MUL launches once lu clears
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("prio_lu", 32'(ctl), 32'(STALL));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("prio_mul_launch", 32'(ctl), 32'(MUL_LAUNCH));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("prio_busy1", 32'(ctl), 32'(BUSY_STALL));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("prio_busy2", 32'(ctl), 32'(BUSY_STALL));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("prio_busy3", 32'(ctl), 32'(BUSY_GO));
    idle();
    check("prio_cnt", stall_count, 32'd7);

    // Taken branch in IDLE flushes for one cycle without stalling
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("br_flush", 32'(ctl), 32'(FLUSH));
    idle();
    check("br_after", 32'(ctl), 32'(NORMAL));

    // Reset on the second MUL_BUSY cycle aborts the MUL
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_launch", 32'(ctl), 32'(MUL_LAUNCH));
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_busy1", 32'(ctl), 32'(BUSY_STALL));
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_rst_ctl", 32'(ctl), 32'(NORMAL));
    idle();
    check("abort_after_ctl", 32'(ctl), 32'(NORMAL));
    check("abort_after_cnt", stall_count, 32'd0);

    // Saturation: preload the counter just below all-ones, then keep stalling
    drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_stall0", 32'(ctl), 32'(STALL));
    force dut.stall_count = 32'hFFFF_FFFD;
    #1;
    release dut.stall_count;
    check("sat_preload", stall_count, 32'hFFFF_FFFD);
    drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_fffe", stall_count, 32'hFFFF_FFFE);
    drive(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sat_ffff", stall_count, 32'hFFFF_FFFF);
    idle();
    check("sat_hold", stall_count, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
